// File: rtl/motor_setpoint_entry.sv
// motor_setpoint_entry
// Operator front end for motor setpoints. Five debounced buttons select a motor,
// edit its decimal setpoint one digit at a time, and commit the binary value
// to the motor control logic with a single-cycle valid strobe. Up/Down auto-repeat
// while held in EDIT.
module motor_setpoint_entry #(
  parameter int NUM_MOTORS    = 6,
  parameter int NUM_DIGITS    = 3,
  parameter int VAL_W         = 10,
  parameter int HOLD_CYCLES   = 5000000,
  parameter int REPEAT_CYCLES = 1000000,
  localparam int MOT_W        = $clog2(NUM_MOTORS),
  localparam int DIG_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    btn_up,
  input  logic                    btn_down,
  input  logic                    btn_enter,
  output logic [MOT_W-1:0]        motor_sel,
  output logic                    editing,
  output logic [DIG_W-1:0]        digit_sel,
  output logic [4*NUM_DIGITS-1:0] digits_disp,
  output logic [VAL_W-1:0]        value,
  output logic [MOT_W-1:0]        value_motor,
  output logic                    value_valid
);

  // The repeat counter must reach HOLD_CYCLES+1 in the hold phase and REPEAT_CYCLES afterwards.
  localparam int CNT_MAX = (HOLD_CYCLES + 1 > REPEAT_CYCLES) ? HOLD_CYCLES + 1 : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic {SELECT, EDIT} state_t;

  state_t           state, state_next;
  logic [4:0]       btn_now, btn_prev, press;
  logic [3:0]       store [NUM_MOTORS][NUM_DIGITS];
  logic             act_enter, act_left, act_right, act_up, act_down, any_press;
  logic             rep_active, rep_up, rep_phase, rep_held, rep_fire;
  logic [CNT_W-1:0] rep_cnt, rep_limit;
  logic             do_inc, do_dec;
  logic [3:0]       cur_digit;
  logic [VAL_W-1:0] commit_value;

  assign btn_now   = {btn_enter, btn_left, btn_right, btn_up, btn_down};
  assign press     = btn_now & ~btn_prev;
  assign any_press = |press;
  assign editing   = (state == EDIT);

  // Priority decode: only the highest-priority press event of a cycle acts.
  always_comb begin
    act_enter = press[4];
    act_left  = press[3] & ~press[4];
    act_right = press[2] & ~(|press[4:3]);
    act_up    = press[1] & ~(|press[4:2]);
    act_down  = press[0] & ~(|press[4:1]);
  end

  // Auto-repeat fires when the held button's counter reaches the current phase limit.
  always_comb begin
    rep_held  = rep_up ? btn_up : btn_down;
    rep_limit = rep_phase ? CNT_W'(REPEAT_CYCLES) : CNT_W'(HOLD_CYCLES + 1);
    rep_fire  = 1'b0;
    if (!any_press && rep_active && rep_held && (state == EDIT) && (rep_cnt == rep_limit))
      rep_fire = 1'b1;
    do_inc    = (state == EDIT) && (act_up || (rep_fire && rep_up));
    do_dec    = (state == EDIT) && (act_down || (rep_fire && !rep_up));
  end

  // Current cursor digit, the display bus and the binary value of the selected motor.
  always_comb begin
    cur_digit    = store[motor_sel][digit_sel];
    digits_disp  = '0;
    commit_value = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digits_disp[4*(NUM_DIGITS-1-i) +: 4] = store[motor_sel][i];
      commit_value = VAL_W'(int'(commit_value) * 10 + int'(store[motor_sel][i]));
    end
  end

  // Next-state logic: enter toggles between SELECT and EDIT.
  always_comb begin
    state_next = state;
    case (state)
      SELECT:  if (act_enter) state_next = EDIT;
      EDIT:    if (act_enter) state_next = SELECT;
      default: state_next = SELECT;
    endcase
  end

  // State register and button history; history resets high so held buttons do not act.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SELECT;
      btn_prev <= '1;
    end else begin
      state    <= state_next;
      btn_prev <= btn_now;
    end
  end

  // Cursor, motor selection and the commit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      motor_sel   <= '0;
      digit_sel   <= '0;
      value       <= '0;
      value_motor <= '0;
      value_valid <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      if (state == SELECT) begin
        if (act_enter) begin
          digit_sel <= '0;
        end else if (act_left) begin
          motor_sel <= (motor_sel == '0) ? MOT_W'(NUM_MOTORS - 1) : motor_sel - MOT_W'(1);
        end else if (act_right) begin
          motor_sel <= (motor_sel == MOT_W'(NUM_MOTORS - 1)) ? '0 : motor_sel + MOT_W'(1);
        end
      end else begin
        if (act_enter) begin
          value       <= commit_value;
          value_motor <= motor_sel;
          value_valid <= 1'b1;
        end else if (act_left) begin
          digit_sel <= (digit_sel == '0) ? DIG_W'(NUM_DIGITS - 1) : digit_sel - DIG_W'(1);
        end else if (act_right) begin
          digit_sel <= (digit_sel == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_sel + DIG_W'(1);
        end
      end
    end
  end

  // Per-motor digit store; digits wrap within 0..9 without carry or borrow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < NUM_MOTORS; m++)
        for (int d = 0; d < NUM_DIGITS; d++)
          store[m][d] <= 4'd0;
    end else if (do_inc) begin
      store[motor_sel][digit_sel] <= (cur_digit >= 4'd9) ? 4'd0 : cur_digit + 4'd1;
    end else if (do_dec) begin
      store[motor_sel][digit_sel] <= (cur_digit == 4'd0) ? 4'd9 : cur_digit - 4'd1;
    end
  end

  // Auto-repeat tracking: armed by an acting Up/Down press, disarmed by release or any other press.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_active <= 1'b0;
      rep_up     <= 1'b0;
      rep_phase  <= 1'b0;
      rep_cnt    <= '0;
    end else if (any_press) begin
      if ((state == EDIT) && (act_up || act_down) && (HOLD_CYCLES > 0)) begin
        rep_active <= 1'b1;
        rep_up     <= act_up;
        rep_phase  <= 1'b0;
        rep_cnt    <= CNT_W'(1);
      end else begin
        rep_active <= 1'b0;
        rep_phase  <= 1'b0;
        rep_cnt    <= '0;
      end
    end else if (rep_active && rep_held && (state == EDIT)) begin
      if (rep_fire) begin
        rep_phase <= 1'b1;
        rep_cnt   <= CNT_W'(1);
      end else begin
        rep_cnt   <= rep_cnt + CNT_W'(1);
      end
    end else begin
      rep_active <= 1'b0;
      rep_phase  <= 1'b0;
      rep_cnt    <= '0;
    end
  end

endmodule

// File: tb/tb_motor_setpoint_entry.sv
// tb_motor_setpoint_entry
// Directed, table-driven bench for motor_setpoint_entry with short auto-repeat timing.
module tb_motor_setpoint_entry;

  logic        clk;
  logic        rst;
  logic        btn_left, btn_right, btn_up, btn_down, btn_enter;
  logic [2:0]  motor_sel;
  logic        editing;
  logic [1:0]  digit_sel;
  logic [11:0] digits_disp;
  logic [9:0]  value;
  logic [2:0]  value_motor;
  logic        value_valid;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [4:0] B_E = 5'b10000;
  localparam logic [4:0] B_L = 5'b01000;
  localparam logic [4:0] B_R = 5'b00100;
  localparam logic [4:0] B_U = 5'b00010;
  localparam logic [4:0] B_D = 5'b00001;

  typedef struct {
    logic [4:0] btn;
    int         ms;
    int         ed;
    int         ds;
    int         disp;
    int         vv;
    int         val;
    int         vm;
  } vec_t;

  vec_t vecs [33];

  motor_setpoint_entry #(
    .NUM_MOTORS(6), .NUM_DIGITS(3), .VAL_W(10), .HOLD_CYCLES(4), .REPEAT_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
    .btn_down(btn_down), .btn_enter(btn_enter),
    .motor_sel(motor_sel), .editing(editing), .digit_sel(digit_sel),
    .digits_disp(digits_disp), .value(value), .value_motor(value_motor),
    .value_valid(value_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one button pattern for one clock, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic [4:0] b);
    {btn_enter, btn_left, btn_right, btn_up, btn_down} = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  initial begin
    int exp_low [9];

    vecs[0]  = '{B_L, 5, 0, 0, 'h000, 0, 0, 0};
    vecs[1]  = '{B_R, 0, 0, 0, 'h000, 0, 0, 0};
    vecs[2]  = '{B_R, 1, 0, 0, 'h000, 0, 0, 0};
    vecs[3]  = '{B_R, 2, 0, 0, 'h000, 0, 0, 0};
    vecs[4]  = '{B_R, 3, 0, 0, 'h000, 0, 0, 0};
    vecs[5]  = '{B_R, 4, 0, 0, 'h000, 0, 0, 0};
    vecs[6]  = '{B_R, 5, 0, 0, 'h000, 0, 0, 0};
    vecs[7]  = '{B_R, 0, 0, 0, 'h000, 0, 0, 0};
    vecs[8]  = '{B_R, 1, 0, 0, 'h000, 0, 0, 0};
    vecs[9]  = '{B_R, 2, 0, 0, 'h000, 0, 0, 0};
    vecs[10] = '{B_E, 2, 1, 0, 'h000, 0, 0, 0};
    vecs[11] = '{B_R, 2, 1, 1, 'h000, 0, 0, 0};
    vecs[12] = '{B_R, 2, 1, 2, 'h000, 0, 0, 0};
    vecs[13] = '{B_U, 2, 1, 2, 'h001, 0, 0, 0};
    vecs[14] = '{B_U, 2, 1, 2, 'h002, 0, 0, 0};
    vecs[15] = '{B_U, 2, 1, 2, 'h003, 0, 0, 0};
    vecs[16] = '{B_L, 2, 1, 1, 'h003, 0, 0, 0};
    vecs[17] = '{B_D, 2, 1, 1, 'h093, 0, 0, 0};
    vecs[18] = '{B_E, 2, 0, 0, 'h093, 1, 93, 2};
    vecs[19] = '{B_R, 3, 0, 0, 'h000, 0, 93, 2};
    vecs[20] = '{B_L, 2, 0, 0, 'h093, 0, 93, 2};
    vecs[21] = '{B_E, 2, 1, 0, 'h093, 0, 93, 2};
    vecs[22] = '{B_D, 2, 1, 0, 'h993, 0, 93, 2};
    vecs[23] = '{B_E, 2, 0, 0, 'h993, 1, 993, 2};
    vecs[24] = '{B_E, 2, 1, 0, 'h993, 0, 993, 2};
    vecs[25] = '{B_E | B_U, 2, 0, 0, 'h993, 1, 993, 2};
    vecs[26] = '{B_E, 2, 1, 0, 'h993, 0, 993, 2};
    vecs[27] = '{B_R, 2, 1, 1, 'h993, 0, 993, 2};
    vecs[28] = '{B_R, 2, 1, 2, 'h993, 0, 993, 2};
    vecs[29] = '{B_U, 2, 1, 2, 'h994, 0, 993, 2};
    vecs[30] = '{B_U, 2, 1, 2, 'h995, 0, 993, 2};
    vecs[31] = '{B_U, 2, 1, 2, 'h996, 0, 993, 2};
    vecs[32] = '{B_U, 2, 1, 2, 'h997, 0, 993, 2};

    // Hold-up trace from digit 7: steps at the press edge and 5 and 7 edges later.
    exp_low = '{8, 8, 8, 8, 8, 9, 9, 0, 0};

    // Reset with Up held throughout.
    rst = 1'b1;
    {btn_enter, btn_left, btn_right, btn_up, btn_down} = B_U;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset motor_sel", motor_sel, 0);
    checkOutput("reset editing", editing, 0);
    checkOutput("reset digit_sel", digit_sel, 0);
    checkOutput("reset digits_disp", digits_disp, 0);
    checkOutput("reset value", value, 0);
    checkOutput("reset value_motor", value_motor, 0);
    checkOutput("reset value_valid", value_valid, 0);
    rst = 1'b0;
    applyStimulus(B_U);
    checkOutput("held-through-reset motor_sel", motor_sel, 0);
    checkOutput("held-through-reset editing", editing, 0);
    applyStimulus(5'b0);
    applyStimulus(B_U);
    checkOutput("select up motor_sel", motor_sel, 0);
    checkOutput("select up digits_disp", digits_disp, 0);
    checkOutput("select up editing", editing, 0);
    applyStimulus(5'b0);

    // Table of single presses, each followed by a release cycle.
    for (int i = 0; i < 33; i++) begin
      applyStimulus(vecs[i].btn);
      checkOutput($sformatf("vec%0d motor_sel", i), motor_sel, vecs[i].ms);
      checkOutput($sformatf("vec%0d editing", i), editing, vecs[i].ed);
      if (vecs[i].ed == 1)
        checkOutput($sformatf("vec%0d digit_sel", i), digit_sel, vecs[i].ds);
      checkOutput($sformatf("vec%0d digits_disp", i), digits_disp, vecs[i].disp);
      checkOutput($sformatf("vec%0d value_valid", i), value_valid, vecs[i].vv);
      checkOutput($sformatf("vec%0d value", i), value, vecs[i].val);
      checkOutput($sformatf("vec%0d value_motor", i), value_motor, vecs[i].vm);
      applyStimulus(5'b0);
      checkOutput($sformatf("vec%0d value_valid release", i), value_valid, 0);
    end

    // Auto-repeat: hold Up for 9 cycles on digit 7 of motor 2.
    for (int k = 0; k < 9; k++) begin
      applyStimulus(B_U);
      checkOutput($sformatf("hold k%0d digits_disp", k), digits_disp, 'h990 + exp_low[k]);
      checkOutput($sformatf("hold k%0d value_valid", k), value_valid, 0);
    end
    applyStimulus(5'b0);
    checkOutput("after hold digits_disp", digits_disp, 'h990);
    applyStimulus(5'b0);
    checkOutput("after hold idle digits_disp", digits_disp, 'h990);
    checkOutput("after hold editing", editing, 1);

    // Reset in the middle of an edit clears everything without a strobe.
    rst = 1'b1;
    applyStimulus(5'b0);
    checkOutput("mid-edit reset value_valid", value_valid, 0);
    checkOutput("mid-edit reset editing", editing, 0);
    checkOutput("mid-edit reset motor_sel", motor_sel, 0);
    checkOutput("mid-edit reset value", value, 0);
    checkOutput("mid-edit reset value_motor", value_motor, 0);
    rst = 1'b0;
    applyStimulus(5'b0);
    applyStimulus(B_R);
    applyStimulus(5'b0);
    applyStimulus(B_R);
    checkOutput("post-reset motor_sel", motor_sel, 2);
    checkOutput("post-reset motor2 digits_disp", digits_disp, 0);
    checkOutput("post-reset value_valid", value_valid, 0);
    applyStimulus(5'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
